mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer that shares one single-port Memory
//   (DW x W) between NREQ requesters. Latches the winning request, drives one
//   memory access cycle, returns read data and a one-cycle ack. Sits between
//   client FSMs and the Memory/BusDriver pair; top level resolves the tristate.
// PARAMETERS
//   NREQ  4               number of requesters (>= 2, any value)
//   DW    16              memory data width
//   W     256             memory depth (words)
//   AW    $clog2(W)       address width
// PORTS
//   clock      in   1        system clock, all state on posedge
//   reset_L    in   1        async active-low reset
//   req        in   NREQ     request per client; hold high until ack
//   req_we     in   NREQ     1 = write, 0 = read, per client
//   req_addr   in   NREQ*AW  client i address at [i*AW +: AW]
//   req_wdata  in   NREQ*DW  client i write data at [i*DW +: DW]
//   grant      out  NREQ     one-hot owner, high in ACCESS and ACK
//   ack        out  NREQ     one-hot, 1-cycle pulse in ACK
//   rdata      out  DW       read data; valid in ACK of a read, held after
//   busy       out  1        high in ACCESS and ACK
//   mem_re     out  1        memory read enable
//   mem_we     out  1        memory write enable
//   mem_addr   out  AW       memory address
//   mem_wdata  out  DW       data for memory write (to BusDriver)
//   mem_rdata  in   DW       data from memory bus
// BEHAVIOUR
//   Reset (async, reset_L=0): state IDLE, rr_ptr=0, all outputs 0
//     (grant, ack, rdata, busy, mem_re, mem_we, mem_addr, mem_wdata).
//   FSM IDLE -> ACCESS -> ACK -> IDLE; each transaction exactly 3 cycles.
//   IDLE: if |req, winner = first i with req[i]=1 scanning rr_ptr,
//     rr_ptr+1, ... mod NREQ. Latch winner id, req_we, req_addr, req_wdata
//     of winner; go ACCESS. No req: stay IDLE.
//   ACCESS: mem_addr=latched addr; write: mem_we=1, mem_wdata=latched data;
//     read: mem_re=1. On edge ending ACCESS, read captures mem_rdata into
//     rdata (write leaves rdata unchanged). Go ACK.
//   ACK: mem_re=mem_we=0; ack[winner]=1; rr_ptr <= (winner+1) mod NREQ; go IDLE.
//   mem_addr/mem_wdata registered, hold last value outside ACCESS.
//   Requester drops req on edge ending its ACK; req still high in IDLE
//     is a new request.
//   Latency: req high at edge k -> ACCESS cycle k+1, ack in cycle k+2.
//   Req deasserted or inputs changed after latch: ignored; transaction
//     completes with latched values, ack still issued.
//   All NREQ requesting: served in rotation, no client waits > NREQ txns.
//   Single requester: served back-to-back, one txn per 3 cycles.
//   Reset mid-op: immediate abort; no ack; write in ACCESS may not complete.
//   Never more than one bit of grant/ack set; mem_re & mem_we never both 1.
// TESTING
//   Reset: reset_L=0 mid-ACCESS -> all outputs 0 same cycle, IDLE, rr_ptr=0.
//   Single write/read: c1 writes 0xBEEF @0x10, then reads 0x10 -> mem_we 1
//     cycle with addr 0x10; read ack[1] with rdata=0xBEEF, 3 cycles each.
//   Contention: req=4'b1111 held, rr_ptr=0 -> grant order 0,1,2,3,0; each
//     client's ack 3 cycles apart.
//   Rotation skip: rr_ptr=2, req=4'b0011 -> grant 0 first, then 1.
//   Withdrawal: c2 drops req during ACCESS -> ack[2] still pulses, next
//     IDLE ignores c2.
//   Input change: c0 changes addr 0x05->0x06 after latch -> mem_addr=0x05.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory between NREQ clients.
// Each transaction runs IDLE -> ACCESS -> ACK with all outputs registered.
module mem_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int W    = 256,
  parameter int AW   = $clog2(W)
) (
  input  logic                 clock,
  input  logic                 reset_L,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int          IW = $clog2(NREQ);
  localparam int unsigned N  = NREQ;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t      state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic          owner_we;
  logic [IW-1:0] pick;
  logic          found;
  int unsigned   scan;

  // Scan starts at rr_ptr and wraps modulo NREQ, so NREQ need not be a power of two.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    scan  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan = 32'(rr_ptr) + k;
      if (scan >= N) scan = scan - N;
      if (!found && req[scan[IW-1:0]]) begin
        found = 1'b1;
        pick  = scan[IW-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      owner_we  <= 1'b0;
      grant     <= '0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner    <= pick;
            owner_we <= req_we[pick];
            // mem_addr/mem_wdata double as the latched request fields.
            mem_addr <= req_addr[32'(pick)*AW +: AW];
            if (req_we[pick]) mem_wdata <= req_wdata[32'(pick)*DW +: DW];
            mem_we   <= req_we[pick];
            mem_re   <= !req_we[pick];
            grant    <= NREQ'(1) << pick;
            busy     <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!owner_we) rdata <= mem_rdata;
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          ack    <= grant;
          state  <= ACK;
        end
        ACK: begin
          ack    <= '0;
          grant  <= '0;
          busy   <= 1'b0;
          rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clock) disable iff (!reset_L) $onehot0(grant));
  a_ack_onehot:   assert property (@(posedge clock) disable iff (!reset_L) $onehot0(ack));
  a_re_we_excl:   assert property (@(posedge clock) disable iff (!reset_L) !(mem_re && mem_we));

endmodule
